rd_fake_tx: RTL

Downstream consumer of the stretched fake-RD trigger. On each accepted rising edge of the stretched trigger, the block waits a fixed delay, then serializes a fake radio-detector event frame on a single line. The frame is a start bit, an event number MSB first, an even-parity bit and a stop bit. The block also keeps an event counter and a saturating count of triggers dropped while a frame is in flight.

---
 rtl/rd_fake_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rd_fake_tx.sv
// rd_fake_tx: on an accepted rising edge of the stretched fake-RD trigger,
// waits DELAY cycles and then serializes a frame on DATA_OUT made of a start
// bit, the NBITS-wide event number (MSB first), an even-parity bit and a
// stop bit. Edges that arrive while a frame is pending are counted in a
// saturating MISSED counter.
module rd_fake_tx #(
  parameter int NBITS   = 16,
  parameter int CLK_DIV = 4,
  parameter int DELAY   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TRIG_IN,
  input  logic             ENABLE,
  output logic             DATA_OUT,
  output logic             BUSY,
  output logic [NBITS-1:0] EVT_COUNT,
  output logic [7:0]       MISSED
);

  // One down-counter serves both the WAIT delay and the bit periods.
  localparam int CMAX = (DELAY > CLK_DIV) ? DELAY : CLK_DIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_reg,  state_next;
  logic [CW-1:0]    cnt_reg,    cnt_next;
  logic [BW-1:0]    bit_reg,    bit_next;
  logic [NBITS-1:0] shift_reg,  shift_next;
  logic [NBITS-1:0] evt_reg,    evt_next;
  logic             parity_reg, parity_next;
  logic [7:0]       missed_reg, missed_next;
  logic             dout_reg,   dout_next;
  logic             trig_d_reg;
  logic             edge_det;
  logic             period_end;

  // trig_d resets high so a trigger held through reset release is not an edge.
  assign edge_det   = TRIG_IN & ~trig_d_reg;
  assign period_end = (cnt_reg == '0);

  // Next-state, counters, payload latch and the value DATA_OUT takes next cycle.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    evt_next    = evt_reg;
    parity_next = parity_reg;
    missed_next = missed_reg;
    dout_next   = 1'b0;

    // Any edge outside IDLE is dropped, whatever ENABLE says.
    if (edge_det && (state_reg != S_IDLE) && (missed_reg != 8'hFF)) begin
      missed_next = missed_reg + 8'd1;
    end

    case (state_reg)
      S_IDLE: begin
        if (edge_det && ENABLE) begin
          evt_next    = evt_reg + NBITS'(1);
          shift_next  = evt_next;
          parity_next = ^evt_next;
          cnt_next    = CW'(DELAY - 1);
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (period_end) begin
          cnt_next   = CW'(CLK_DIV - 1);
          state_next = S_START;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_START: begin
        if (period_end) begin
          cnt_next   = CW'(CLK_DIV - 1);
          bit_next   = BW'(NBITS - 1);
          state_next = S_DATA;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_DATA: begin
        if (period_end) begin
          cnt_next = CW'(CLK_DIV - 1);
          if (bit_reg == '0) begin
            state_next = S_PARITY;
          end else begin
            bit_next   = bit_reg - BW'(1);
            shift_next = shift_reg << 1;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_PARITY: begin
        if (period_end) begin
          cnt_next   = CW'(CLK_DIV - 1);
          state_next = S_STOP;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_STOP: begin
        if (period_end) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    // DATA_OUT is registered, so it is derived from where the FSM goes next.
    case (state_next)
      S_START:  dout_next = 1'b1;
      S_DATA:   dout_next = shift_next[NBITS-1];
      S_PARITY: dout_next = parity_next;
      default:  dout_next = 1'b0;
    endcase
  end

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      evt_reg    <= '0;
      parity_reg <= 1'b0;
      missed_reg <= 8'd0;
      dout_reg   <= 1'b0;
      trig_d_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      evt_reg    <= evt_next;
      parity_reg <= parity_next;
      missed_reg <= missed_next;
      dout_reg   <= dout_next;
      trig_d_reg <= TRIG_IN;
    end
  end

  assign DATA_OUT  = dout_reg;
  assign BUSY      = (state_reg != S_IDLE);
  assign EVT_COUNT = evt_reg;
  assign MISSED    = missed_reg;

endmodule
